// File: rtl/mult_accumulator.sv
// Block accumulator for a pipelined multiplier: sums BLOCK_LEN products per word into a small output FIFO.
// Optional feature: define MULT_ACC_SATURATE_EN for signed saturating adds with a per-word sat flag.
module mult_accumulator #(
  parameter int ACC_W      = 64,
  parameter int BLOCK_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [63:0]      product,
  input  logic             clear,
  input  logic             sum_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum,
  output logic             sum_sat,
  output logic             drop_err
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_blk_sat;
  logic [ACC_W:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic                    r_drop_err;

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_add;
  logic                    w_base_sat;
  logic                    w_add_sat;
  logic                    w_blk_sat;
  logic [CNT_W-1:0]        w_base_cnt;
  logic                    w_last;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  // clear acts before the add so a product arriving with clear starts a fresh block
  assign w_ext      = ACC_W'($signed(product));
  assign w_base     = clear ? '0 : r_acc;
  assign w_base_sat = clear ? 1'b0 : r_blk_sat;
  assign w_base_cnt = clear ? '0 : r_cnt;

`ifdef MULT_ACC_SATURATE_EN
  logic [ACC_W:0] w_wide;
  assign w_wide = {w_base[ACC_W-1], w_base} + {w_ext[ACC_W-1], w_ext};
  always_comb begin
    w_add_sat = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    w_add     = w_wide[ACC_W-1:0];
    if (w_add_sat)
      w_add = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign w_add     = w_base + w_ext;
  assign w_add_sat = 1'b0;
`endif

  assign w_blk_sat = w_base_sat | w_add_sat;
  assign w_last    = valid_in && (w_base_cnt == CNT_W'(BLOCK_LEN - 1));
  assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_pop     = sum_valid && sum_ready;
  assign w_push    = w_last && (!w_full || w_pop);
  assign w_drop    = w_last && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_blk_sat <= 1'b0;
    end else if (valid_in) begin
      if (w_last) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_blk_sat <= 1'b0;
      end else begin
        r_acc     <= w_add;
        r_cnt     <= w_base_cnt + 1'b1;
        r_blk_sat <= w_blk_sat;
      end
    end else if (clear) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_blk_sat <= 1'b0;
    end
  end

  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {w_blk_sat, w_add};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
      if (w_drop)
        r_drop_err <= 1'b1;
    end
  end

  assign sum_valid = (r_count != '0);
  assign sum       = sum_valid ? r_mem[r_rd_ptr][ACC_W-1:0] : '0;
  assign sum_sat   = sum_valid & r_mem[r_rd_ptr][ACC_W];
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator (default parameters); expected words are queued when a block completes.
module tb_mult_accumulator;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [63:0] product;
  logic        clear;
  logic        sum_ready;
  logic        sum_valid;
  logic [63:0] sum;
  logic        sum_sat;
  logic        drop_err;

  mult_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .product   (product),
    .clear     (clear),
    .sum_ready (sum_ready),
    .sum_valid (sum_valid),
    .sum       (sum),
    .sum_sat   (sum_sat),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [64:0] sb_q[$];
  logic [63:0] m_acc;
  int          m_cnt;
  logic        m_sat;
  logic        m_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  function automatic logic [64:0] model_add(input logic [63:0] a, input logic [63:0] p);
    logic [64:0] w;
    w = {a[63], a} + {p[63], p};
`ifdef MULT_ACC_SATURATE_EN
    if (w[64] != w[63])
      return {1'b1, (w[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)};
`endif
    return {1'b0, w[63:0]};
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_acc  = '0;
    m_cnt  = 0;
    m_sat  = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(sum_valid), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check({tag, ".sum"}, sum, sb_q[0][63:0]);
      check({tag, ".sat"}, 64'(sum_sat), 64'(sb_q[0][64]));
    end
    check({tag, ".drop"}, 64'(drop_err), 64'(m_drop));
  endtask

  // one clock: drive on the falling edge, update the model on the rising edge, check 1 time unit later
  task automatic step(input string tag, input logic v, input logic [63:0] p, input logic clr, input logic rdy);
    logic [63:0] base;
    logic        bsat;
    int          bcnt;
    logic [64:0] r;
    logic        pop;
    @(negedge clk);
    valid_in  = v;
    product   = p;
    clear     = clr;
    sum_ready = rdy;
    pop = rdy && (sb_q.size() != 0);
    @(posedge clk);
    base = clr ? 64'd0 : m_acc;
    bsat = clr ? 1'b0 : m_sat;
    bcnt = clr ? 0 : m_cnt;
    if (pop) void'(sb_q.pop_front());
    if (v) begin
      r = model_add(base, p);
      if (bcnt == 3) begin
        if (sb_q.size() < DEPTH) sb_q.push_back({bsat | r[64], r[63:0]});
        else m_drop = 1'b1;
        m_acc = '0; m_cnt = 0; m_sat = 1'b0;
      end else begin
        m_acc = r[63:0]; m_cnt = bcnt + 1; m_sat = bsat | r[64];
      end
    end else begin
      m_acc = base; m_cnt = bcnt; m_sat = bsat;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 64'd0, 1'b0, rdy);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    valid_in = 1'b0; clear = 1'b0; sum_ready = 1'b0; product = '0;
    model_reset();
    #1;
    check({tag, ".valid"}, 64'(sum_valid), 64'd0);
    check({tag, ".sum"}, sum, 64'd0);
    check({tag, ".sat"}, 64'(sum_sat), 64'd0);
    check({tag, ".drop"}, 64'(drop_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] big;
    rst = 1'b0; valid_in = 1'b0; product = '0; clear = 1'b0; sum_ready = 1'b0;
    model_reset();
    #1;
    check("rst.valid", 64'(sum_valid), 64'd0);
    check("rst.sum", sum, 64'd0);
    check("rst.sat", 64'(sum_sat), 64'd0);
    check("rst.drop", 64'(drop_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // basic block: 30 - 30 + 16 + 4 = 20
    step("b0", 1'b1, 64'd30, 1'b0, 1'b1);
    step("b1", 1'b1, -64'sd30, 1'b0, 1'b1);
    step("b2", 1'b1, 64'd16, 1'b0, 1'b1);
    step("b3", 1'b1, 64'd4, 1'b0, 1'b1);
    check("basic.q", 64'(sb_q.size()), 64'd1);
    idle("basic.drain", 2, 1'b1);

    // overflow of the FIFO with no consumer, then drain
    for (int i = 0; i < 20; i++) step("fill", 1'b1, 64'd1, 1'b0, 1'b0);
    check("fill.drop_model", 64'(m_drop), 64'd1);
    idle("fill.drain", 6, 1'b1);

    do_reset("rst2");

    // full FIFO, push and pop on the same edge
    for (int i = 0; i < 16; i++) step("full", 1'b1, 64'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pp", 1'b1, 64'd2, 1'b0, 1'b0);
    step("pp.last", 1'b1, 64'd2, 1'b0, 1'b1);
    check("pp.tail", sb_q[DEPTH-1][63:0], 64'd8);
    idle("pp.drain", 6, 1'b1);

    // clear with a simultaneous product restarts the block
    step("c0", 1'b1, 64'd7, 1'b0, 1'b1);
    step("c1", 1'b1, 64'd7, 1'b0, 1'b1);
    step("c2", 1'b1, 64'd5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("c3", 1'b1, 64'd1, 1'b0, 1'b1);
    idle("clr.drain", 2, 1'b1);

    // large positive products: saturate or wrap depending on build
    big = 64'h4000_0000_0000_0000;
    for (int i = 0; i < 4; i++) step("big", 1'b1, big, 1'b0, 1'b0);
`ifdef MULT_ACC_SATURATE_EN
    check("big.sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
    check("big.sat", 64'(sum_sat), 64'd1);
`else
    check("big.sum", sum, 64'd0);
    check("big.sat", 64'(sum_sat), 64'd0);
`endif
    idle("big.drain", 2, 1'b1);

    // reset mid-operation with queued and partial work
    for (int i = 0; i < 10; i++) step("mid", 1'b1, 64'd1, 1'b0, 1'b0);
    check("mid.q", 64'(sb_q.size()), 64'd2);
    do_reset("rst3");
    for (int i = 0; i < 4; i++) step("post", 1'b1, 64'd1, 1'b0, 1'b1);
    check("post.sum", sum, 64'd4);
    idle("post.drain", 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
